prog_loader: RTL



---
 rtl/prog_loader_pkg.sv | 43 ++++
 rtl/prog_loader_ctr.sv | 30 +++
 rtl/prog_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, stream header layout,
// counter widths and memory address strides.
package prog_loader_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_IMEM = 3'd2;
    localparam logic [2:0] S_DMEM = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_HDR  = S_HDR,
        ST_IMEM = S_IMEM,
        ST_DMEM = S_DMEM,
        ST_CHK  = S_CHK,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE,
        ST_ERR  = S_ERR
    } state_t;

    localparam int CNT_W = 16;
    localparam int RUN_W = 32;

    localparam int HDR_NI_LSB  = 0;
    localparam int HDR_NI_MSB  = 15;
    localparam int HDR_ND_LSB  = 16;
    localparam int HDR_ND_MSB  = 31;
    localparam int HDR_RUN_LSB = 32;
    localparam int HDR_RUN_MSB = 63;

    localparam logic [63:0] IMEM_STRIDE = 64'd4;
    localparam logic [63:0] DMEM_STRIDE = 64'd8;

    // States in which the loader is parked and will react to start.
    function automatic logic is_parked(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/prog_loader_ctr.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module prog_loader_ctr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader in front of the CPU core's external memory ports. Optional trailer
// checksum is compiled in with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [CNT_W:0] IMEM_LIMIT = (CNT_W+1)'(IMEM_DEPTH);
    localparam logic [CNT_W:0] DMEM_LIMIT = (CNT_W+1)'(DMEM_DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = ST_CHK;
`else
    localparam state_t PAYLOAD_END = ST_RUN;
`endif

    state_t state, state_next;

    logic             beat;
    logic             session_start;
    logic [CNT_W-1:0] hdr_ni;
    logic [CNT_W-1:0] hdr_nd;
    logic [RUN_W-1:0] hdr_run;
    logic             ni_over;
    logic             nd_over;

    logic [CNT_W-1:0] nd_q;
    logic             run_open;
    logic [63:0]      imem_ptr;
    logic [63:0]      dmem_ptr;

    logic             wctr_load, wctr_dec, wctr_zero;
    logic [CNT_W-1:0] wctr_val;
    logic             rctr_load, rctr_dec, rctr_zero;
    logic [RUN_W-1:0] rctr_val;

    assign hdr_ni  = s_data[HDR_NI_MSB:HDR_NI_LSB];
    assign hdr_nd  = s_data[HDR_ND_MSB:HDR_ND_LSB];
    assign hdr_run = s_data[HDR_RUN_MSB:HDR_RUN_LSB];
    assign ni_over = {1'b0, hdr_ni} > IMEM_LIMIT;
    assign nd_over = {1'b0, hdr_nd} > DMEM_LIMIT;

    assign s_ready       = state inside {ST_HDR, ST_IMEM, ST_DMEM, ST_CHK};
    assign beat          = s_valid && s_ready;
    assign session_start = start && is_parked(state);
    assign busy          = !is_parked(state);
    assign done          = (state == ST_DONE);
    assign error         = (state == ST_ERR);
    assign cpu_enable    = (state == ST_RUN);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [63:0] csum;
    logic        chk_ok;

    assign chk_ok = (s_data == csum);

    // Header and trailer are excluded; instruction words contribute only their low half.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            csum <= '0;
        end else if (session_start) begin
            csum <= '0;
        end else if (beat && (state == ST_IMEM)) begin
            csum <= csum ^ {32'd0, s_data[31:0]};
        end else if (beat && (state == ST_DMEM)) begin
            csum <= csum ^ s_data;
        end
    end
`endif

    // Counters hold "remaining minus one", so the zero flag marks the final beat/cycle.
    prog_loader_ctr #(.WIDTH(CNT_W)) u_word_ctr (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (wctr_load),
        .load_val (wctr_val),
        .dec      (wctr_dec),
        .zero     (wctr_zero)
    );

    prog_loader_ctr #(.WIDTH(RUN_W)) u_run_ctr (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (rctr_load),
        .load_val (rctr_val),
        .dec      (rctr_dec),
        .zero     (rctr_zero)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_next = state;
        wctr_load  = 1'b0;
        wctr_val   = '0;
        wctr_dec   = 1'b0;
        rctr_load  = 1'b0;
        rctr_val   = '0;
        rctr_dec   = 1'b0;

        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_HDR;
                    wctr_load  = 1'b1;
                    rctr_load  = 1'b1;
                end
            end

            ST_HDR: begin
                if (beat) begin
                    if (ni_over || nd_over) begin
                        state_next = ST_ERR;
                    end else begin
                        rctr_load = 1'b1;
                        rctr_val  = (hdr_run == '0) ? '0 : hdr_run - RUN_W'(1);
                        if (hdr_ni != '0) begin
                            state_next = ST_IMEM;
                            wctr_load  = 1'b1;
                            wctr_val   = hdr_ni - CNT_W'(1);
                        end else if (hdr_nd != '0) begin
                            state_next = ST_DMEM;
                            wctr_load  = 1'b1;
                            wctr_val   = hdr_nd - CNT_W'(1);
                        end else begin
                            state_next = PAYLOAD_END;
                        end
                    end
                end
            end

            ST_IMEM: begin
                if (beat) begin
                    wctr_dec = 1'b1;
                    if (wctr_zero) begin
                        if (nd_q != '0) begin
                            state_next = ST_DMEM;
                            wctr_load  = 1'b1;
                            wctr_val   = nd_q - CNT_W'(1);
                        end else begin
                            state_next = PAYLOAD_END;
                        end
                    end
                end
            end

            ST_DMEM: begin
                if (beat) begin
                    wctr_dec = 1'b1;
                    if (wctr_zero) begin
                        state_next = PAYLOAD_END;
                    end
                end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (beat) begin
                    state_next = chk_ok ? ST_RUN : ST_ERR;
                end
            end
`endif

            ST_RUN: begin
                rctr_dec = !run_open;
                if (halt || (!run_open && rctr_zero)) begin
                    state_next = ST_DONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Memory write ports: registered one cycle after the accepting beat; addresses and
    // data hold between writes, only the enables pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            nd_q        <= '0;
            run_open    <= 1'b0;
            imem_ptr    <= '0;
            dmem_ptr    <= '0;
            wen_ext     <= 1'b0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            wen_ext_2   <= 1'b0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;

            if (session_start) begin
                nd_q     <= '0;
                run_open <= 1'b0;
                imem_ptr <= '0;
                dmem_ptr <= '0;
            end

            if (beat && (state == ST_HDR)) begin
                nd_q     <= hdr_nd;
                run_open <= (hdr_run == '0);
            end

            if (beat && (state == ST_IMEM)) begin
                wen_ext   <= 1'b1;
                addr_ext  <= imem_ptr;
                wdata_ext <= s_data[31:0];
                imem_ptr  <= imem_ptr + IMEM_STRIDE;
            end

            if (beat && (state == ST_DMEM)) begin
                wen_ext_2   <= 1'b1;
                addr_ext_2  <= dmem_ptr;
                wdata_ext_2 <= s_data;
                dmem_ptr    <= dmem_ptr + DMEM_STRIDE;
            end
        end
    end

endmodule
